// File: rtl/debug_pkg.sv
// Shared debug-unit definitions: command bytes, default halt word, loader states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package debug_pkg;

  // Host command bytes (ASCII 'L', 'C', 'S', 'N').
  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_NEXT = 8'h4E;

  // Instruction word that terminates a program image.
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READY,
    ST_RUN,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

endpackage

// File: rtl/program_loader_word_packer.sv
// Packs a byte stream big-endian into words and flags the byte that completes a word.
// Latency: word/word_valid are combinational with the completing strobe.
// Backpressure: none, every strobe is accepted; clear wins over strobe.
//
// Ports: clk, reset (sync, active-high), in_byte/strobe (byte input),
//        clear (restart at byte 0), word/word_valid (completed word).
module word_packer #(
  parameter int NB_BYTE = 8,
  parameter int NB_DATA = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NB_BYTE-1:0] in_byte,
  input  logic               strobe,
  input  logic               clear,
  output logic [NB_DATA-1:0] word,
  output logic               word_valid
);

  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int CNT_W   = $clog2(N_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N_BYTES - 1);

  logic [NB_DATA-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // The completed word includes the byte arriving now, so the consumer can
  // register it on the same edge the last byte is shifted in.
  assign word       = {sr_q[NB_DATA-NB_BYTE-1:0], in_byte};
  assign word_valid = strobe && !clear && (cnt_q == LAST_BYTE);

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (strobe) begin
      sr_d  = word;
      cnt_d = cnt_q + CNT_W'(1);  // wraps back to byte 0 after the last byte
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Debug front end: loads a byte stream into instruction memory, then runs the pipeline.
// Latency: every output is registered, one cycle after the i_rx_done / i_halt causing it.
// Backpressure: none; bytes are accepted every cycle, including the memory write cycle.
//
// Ports: i_clk, i_reset (sync, active-high); i_rx_data/i_rx_done from UART;
//        i_halt from pipeline; o_imem_we/addr/data memory write port;
//        o_pipe_reset, o_valid, o_exec_mode, o_step pipeline control;
//        o_prog_loaded, o_error load status.
module program_loader
  import debug_pkg::*;
#(
  parameter int                  NB_BYTE   = 8,
  parameter int                  NB_DATA   = 32,
  parameter int                  NB_ADDR   = 8,
  parameter logic [NB_DATA-1:0]  HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_halt,
  output logic               o_imem_we,
  output logic [NB_ADDR-1:0] o_imem_addr,
  output logic [NB_DATA-1:0] o_imem_data,
  output logic               o_pipe_reset,
  output logic               o_valid,
  output logic               o_exec_mode,
  output logic               o_step,
  output logic               o_prog_loaded,
  output logic               o_error
);

  loader_state_e state_q, state_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic               imem_we_q, imem_we_d;
  logic [NB_ADDR-1:0] imem_addr_q, imem_addr_d;
  logic [NB_DATA-1:0] imem_data_q, imem_data_d;
  logic               pipe_reset_q, pipe_reset_d;
  logic               valid_q, valid_d;
  logic               exec_mode_q, exec_mode_d;
  logic               step_q, step_d;
  logic               prog_loaded_q, prog_loaded_d;
  logic               error_q, error_d;

  logic               pk_strobe, pk_clear, pk_word_valid;
  logic [NB_DATA-1:0] pk_word;
  logic               load_cmd, enter_load;

  word_packer #(
    .NB_BYTE (NB_BYTE),
    .NB_DATA (NB_DATA)
  ) u_packer (
    .clk        (i_clk),
    .reset      (i_reset),
    .in_byte    (i_rx_data),
    .strobe     (pk_strobe),
    .clear      (pk_clear),
    .word       (pk_word),
    .word_valid (pk_word_valid)
  );

  assign load_cmd = i_rx_done && (i_rx_data == CMD_LOAD);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    imem_we_d     = 1'b0;
    imem_addr_d   = imem_addr_q;
    imem_data_d   = imem_data_q;
    pipe_reset_d  = pipe_reset_q;
    valid_d       = valid_q;
    exec_mode_d   = exec_mode_q;
    step_d        = 1'b0;
    prog_loaded_d = prog_loaded_q;
    error_d       = error_q;
    pk_strobe     = 1'b0;
    pk_clear      = 1'b0;
    enter_load    = 1'b0;

    case (state_q)
      ST_IDLE:  enter_load = load_cmd;
      ST_LOAD: begin
        // Every byte is image data here, even if it matches a command value.
        pk_strobe = i_rx_done;
        if (pk_word_valid) begin
          imem_we_d   = 1'b1;
          imem_addr_d = addr_q;
          imem_data_d = pk_word;
          if (pk_word == HALT_WORD) begin
            prog_loaded_d = 1'b1;
            state_d       = ST_READY;
          end else if (addr_q == {NB_ADDR{1'b1}}) begin
            // Last slot used without a halt word: stop rather than wrap.
            error_d = 1'b1;
            state_d = ST_ERROR;
          end else begin
            addr_d = addr_q + NB_ADDR'(1);
          end
        end
      end
      ST_READY: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_CONT || i_rx_data == CMD_STEP) begin
            exec_mode_d  = (i_rx_data == CMD_STEP);
            pipe_reset_d = 1'b0;
            valid_d      = 1'b1;
            state_d      = ST_RUN;
          end
        end
        enter_load = load_cmd;
      end
      ST_RUN: begin
        // Halt takes priority over a coincident step request.
        if (i_halt) begin
          valid_d = 1'b0;
          state_d = ST_DONE;
        end else if (i_rx_done && i_rx_data == CMD_NEXT && exec_mode_q) begin
          step_d = 1'b1;
        end
      end
      ST_DONE:  enter_load = load_cmd;
      ST_ERROR: enter_load = load_cmd;
      default:  state_d = ST_IDLE;
    endcase

    if (enter_load) begin
      state_d       = ST_LOAD;
      addr_d        = '0;
      pk_clear      = 1'b1;
      prog_loaded_d = 1'b0;
      error_d       = 1'b0;
      pipe_reset_d  = 1'b1;
      valid_d       = 1'b0;
      exec_mode_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_data_q   <= '0;
      pipe_reset_q  <= 1'b1;
      valid_q       <= 1'b0;
      exec_mode_q   <= 1'b0;
      step_q        <= 1'b0;
      prog_loaded_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      imem_we_q     <= imem_we_d;
      imem_addr_q   <= imem_addr_d;
      imem_data_q   <= imem_data_d;
      pipe_reset_q  <= pipe_reset_d;
      valid_q       <= valid_d;
      exec_mode_q   <= exec_mode_d;
      step_q        <= step_d;
      prog_loaded_q <= prog_loaded_d;
      error_q       <= error_d;
    end
  end

  assign o_imem_we     = imem_we_q;
  assign o_imem_addr   = imem_addr_q;
  assign o_imem_data   = imem_data_q;
  assign o_pipe_reset  = pipe_reset_q;
  assign o_valid       = valid_q;
  assign o_exec_mode   = exec_mode_q;
  assign o_step        = step_q;
  assign o_prog_loaded = prog_loaded_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed scenarios plus random command/image traffic
// checked against a byte-level reference model and a write scoreboard.
module tb_program_loader;

  localparam int NB_BYTE = 8;
  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 2;
  localparam int DEPTH   = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic               clk = 1'b0;
  logic               i_reset;
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_done;
  logic               i_halt;
  logic               o_imem_we;
  logic [NB_ADDR-1:0] o_imem_addr;
  logic [NB_DATA-1:0] o_imem_data;
  logic               o_pipe_reset, o_valid, o_exec_mode, o_step;
  logic               o_prog_loaded, o_error;

  always #5 clk = ~clk;

  program_loader #(
    .NB_BYTE   (NB_BYTE),
    .NB_DATA   (NB_DATA),
    .NB_ADDR   (NB_ADDR),
    .HALT_WORD (HALT)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_rx_data     (i_rx_data),
    .i_rx_done     (i_rx_done),
    .i_halt        (i_halt),
    .o_imem_we     (o_imem_we),
    .o_imem_addr   (o_imem_addr),
    .o_imem_data   (o_imem_data),
    .o_pipe_reset  (o_pipe_reset),
    .o_valid       (o_valid),
    .o_exec_mode   (o_exec_mode),
    .o_step        (o_step),
    .o_prog_loaded (o_prog_loaded),
    .o_error       (o_error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (byte/transaction level) ----------------
  localparam int M_IDLE = 0, M_LOAD = 1, M_READY = 2, M_RUN = 3, M_DONE = 4, M_ERROR = 5;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  int         m_mode;
  logic [7:0] m_buf[$];
  int         m_addr;
  bit         m_loaded, m_error, m_pres, m_valid, m_exec;
  int         m_steps;
  wr_t        exp_wr[$];
  int         got_steps = 0;

  function automatic void m_reset();
    m_mode = M_IDLE; m_buf.delete(); m_addr = 0;
    m_loaded = 0; m_error = 0; m_pres = 1; m_valid = 0; m_exec = 0;
  endfunction

  function automatic void m_enter_load();
    m_mode = M_LOAD; m_buf.delete(); m_addr = 0;
    m_loaded = 0; m_error = 0; m_pres = 1; m_valid = 0; m_exec = 0;
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    wr_t w;
    case (m_mode)
      M_LOAD: begin
        m_buf.push_back(b);
        if (m_buf.size() == 4) begin
          w.addr = m_addr;
          w.data = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
          m_buf.delete();
          exp_wr.push_back(w);
          if (w.data == HALT) begin
            m_loaded = 1; m_mode = M_READY;
          end else if (m_addr == DEPTH - 1) begin
            m_error = 1; m_mode = M_ERROR;
          end else begin
            m_addr++;
          end
        end
      end
      M_READY: begin
        if (b == 8'h43 || b == 8'h53) begin
          m_mode = M_RUN; m_exec = (b == 8'h53); m_pres = 0; m_valid = 1;
        end else if (b == 8'h4C) begin
          m_enter_load();
        end
      end
      M_RUN: if (b == 8'h4E && m_exec) m_steps++;
      default: if (b == 8'h4C) m_enter_load();  // IDLE, DONE, ERROR
    endcase
  endfunction

  function automatic void m_halt();
    if (m_mode == M_RUN) begin
      m_valid = 0; m_mode = M_DONE;
    end
  endfunction

  // ---------------- monitor: write scoreboard and step counter ----------------
  wr_t mon_e;
  always @(negedge clk) begin
    if (o_step) got_steps++;
    if (o_imem_we) begin
      if (exp_wr.size() == 0) begin
        chk("wr_spurious", 32'(o_imem_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_addr", 32'(o_imem_addr), mon_e.addr);
        chk("wr_data", o_imem_data, mon_e.data);
      end
    end
  end

  // ---------------- drivers (called and returning at a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_data = b; i_rx_done = 1'b1; m_byte(b);
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int i = 3; i >= 0; i--) begin
      send(w[8*i +: 8]);
      if (gap_max > 0) idle($urandom_range(gap_max, 0));
    end
  endtask

  task automatic pulse_halt();
    i_halt = 1'b1; m_halt();
    @(negedge clk);
    i_halt = 1'b0;
  endtask

  task automatic halt_and_byte(input logic [7:0] b);
    i_halt = 1'b1; i_rx_data = b; i_rx_done = 1'b1;
    if (m_mode == M_RUN) m_halt(); else m_byte(b);
    @(negedge clk);
    i_halt = 1'b0; i_rx_done = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; m_reset();
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_pipe_reset"}, 32'(o_pipe_reset), 32'(m_pres));
    chk({tag, "_valid"},      32'(o_valid),      32'(m_valid));
    chk({tag, "_exec_mode"},  32'(o_exec_mode),  32'(m_exec));
    chk({tag, "_loaded"},     32'(o_prog_loaded), 32'(m_loaded));
    chk({tag, "_error"},      32'(o_error),      32'(m_error));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pipe_reset"}, 32'(o_pipe_reset), 32'd1);
    chk({tag, "_other"}, {o_imem_we, o_valid, o_exec_mode, o_step, o_prog_loaded, o_error}, 32'd0);
    chk({tag, "_addr"}, 32'(o_imem_addr), 32'd0);
    chk({tag, "_data"}, o_imem_data, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    int r;
    i_reset = 1'b1; i_rx_data = '0; i_rx_done = 1'b0; i_halt = 1'b0;
    m_steps = 0;
    m_reset();
    idle(2);
    i_reset = 1'b0;
    check_reset_outputs("por");

    // Basic image, bytes back to back so a byte lands in each write cycle.
    send(8'h4C);
    send_word(32'h0000_0001, 0);
    send_word(HALT, 0);
    idle(2);
    check_flags("load");
    chk("load_wr_pending", exp_wr.size(), 0);

    // Step mode: two one-cycle step pulses.
    send(8'h53);
    check_flags("step_mode");
    for (int k = 0; k < 2; k++) begin
      chk("step_before", 32'(o_step), 32'd0);
      send(8'h4E);
      chk("step_pulse", 32'(o_step), 32'd1);
      idle(1);
      chk("step_after", 32'(o_step), 32'd0);
    end
    chk("step_count", got_steps, m_steps);
    pulse_halt();
    check_flags("step_halt");

    // Continuous mode with command-valued data bytes inside the image.
    send(8'h4C);
    send_word(32'h4C43_534E, 1);
    send_word(HALT, 1);
    idle(1);
    send(8'h43);
    check_flags("cont");
    send(8'h4E);
    chk("cont_no_step", 32'(o_step), 32'd0);
    idle(1);
    chk("cont_no_step2", 32'(o_step), 32'd0);
    pulse_halt();
    chk("cont_halt_valid", 32'(o_valid), 32'd0);
    send(8'h4C);
    chk("reload_pipe_reset", 32'(o_pipe_reset), 32'd1);

    // Reset mid-load: partial word must never be written.
    send(8'h00);
    send(8'h00);
    do_reset();
    check_reset_outputs("mid_reset");
    send(8'h00);
    send(8'h00);
    idle(3);
    chk("mid_reset_no_wr", exp_wr.size(), 0);

    // Halt and NEXT together: halt wins.
    send(8'h4C);
    send_word(HALT, 0);
    send(8'h53);
    halt_and_byte(8'h4E);
    chk("sim_no_step", 32'(o_step), 32'd0);
    chk("sim_valid", 32'(o_valid), 32'd0);
    idle(1);
    chk("sim_no_step2", 32'(o_step), 32'd0);

    // Overflow: four non-halt words fill memory.
    send(8'h4C);
    send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 0);
    send_word(32'h3333_3333, 0);
    send_word(32'h4444_4444, 0);
    idle(1);
    check_flags("ovf");
    send_word(32'h5555_5555, 0);
    idle(2);
    chk("ovf_no_wr", exp_wr.size(), 0);
    send(8'h4C);
    check_flags("ovf_clear");
    send_word(32'hA5A5_A5A5, 0);
    send_word(HALT, 0);
    idle(2);
    check_flags("ovf_reload");

    // Random traffic.
    for (int n = 0; n < 250; n++) begin
      if (m_mode == M_LOAD) begin
        w = ($urandom_range(2, 0) == 0) ? HALT : $urandom;
        send_word(w, 2);
      end else begin
        r = $urandom_range(9, 0);
        case (r)
          0, 1:    send(8'h4C);
          2:       send(8'h43);
          3:       send(8'h53);
          4, 5:    send(8'h4E);
          6:       pulse_halt();
          7:       halt_and_byte(8'h4E);
          8:       send(8'($urandom));
          default: do_reset();
        endcase
      end
      idle($urandom_range(1, 0));
      check_flags("rnd");
      idle(1);
      chk("rnd_steps", got_steps, m_steps);
    end

    idle(3);
    chk("end_wr_left", exp_wr.size(), 0);
    chk("end_steps", got_steps, m_steps);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Debug-unit front end that sits between the UART receiver and the MIPS pipeline. It receives the instruction stream byte by byte, packs the bytes into 32-bit words and writes them into instruction memory. It then releases the pipeline in continuous or step mode, according to host commands. It replaces the bare command decoder and owns pipeline reset and valid while a program is loaded.

Parameters:
NB_BYTE, 8, UART data width
NB_DATA, 32, instruction word width
NB_ADDR, 8, instruction-memory word-address width (depth 2**NB_ADDR)
HALT_WORD, 32'hFFFF_FFFF, instruction that terminates the program image

Ports:
i_clk  in  1  system clock (the clk_wiz output)
i_reset  in  1  synchronous, active-high reset
i_rx_data  in  NB_BYTE  received byte, valid when i_rx_done=1
i_rx_done  in  1  one-cycle strobe per received byte
i_halt  in  1  pipeline has retired HALT
o_imem_we  out  1  instruction-memory write strobe, one cycle
o_imem_addr  out  NB_ADDR  word address for the write
o_imem_data  out  NB_DATA  assembled instruction word
o_pipe_reset  out  1  holds the MIPS pipeline in reset
o_valid  out  1  pipeline enable
o_exec_mode  out  1  0 = continuous, 1 = step
o_step  out  1  one-cycle step pulse
o_prog_loaded  out  1  a complete image, ending in HALT_WORD, is in memory
o_error  out  1  image overflowed memory without HALT_WORD

Behaviour:
- Clock and reset: one clock (i_clk); i_reset is synchronous and active-high.
- Reset values: state IDLE, o_pipe_reset=1, all other outputs 0, byte counter 0, address 0. Reset mid-load aborts the load with no further writes.
- Command bytes: CMD_LOAD=8'h4C, CMD_CONT=8'h43, CMD_STEP=8'h53, CMD_NEXT=8'h4E.
- IDLE: CMD_LOAD goes to LOAD, clears the address, byte counter and o_prog_loaded. All other bytes are ignored.
- LOAD, byte packing: each i_rx_done shifts in a byte, big-endian: shift register <= {sr[23:0], i_rx_data}. The 2-bit byte counter wraps 3->0.
- LOAD, write timing: on the 4th byte's i_rx_done, the next cycle has o_imem_we=1, o_imem_data=word and o_imem_addr=current address. The address increments after the write.
- LOAD, no byte loss: bytes arriving in the write cycle are still accepted, because the write is only a registered pulse.
- LOAD, end of image: if the written word equals HALT_WORD, o_prog_loaded=1 and the state goes to READY in the same cycle as the write.
- LOAD, overflow: if the word written at address 2**NB_ADDR-1 is not HALT_WORD, the state goes to ERROR and o_error=1. The address never wraps.
- LOAD, command values: bytes in LOAD are data, never commands.
- READY: CMD_CONT sets o_exec_mode=0, o_pipe_reset=0, o_valid=1 and goes to RUN. CMD_STEP does the same with o_exec_mode=1. CMD_LOAD starts a reload. CMD_NEXT is ignored. Outputs update one cycle after i_rx_done.
- RUN: CMD_NEXT with o_exec_mode=1 gives o_step=1 for exactly one cycle, the cycle after i_rx_done. CMD_NEXT is ignored in continuous mode, and all other bytes are ignored. i_halt=1 sets o_valid=0 and goes to DONE.
- RUN, simultaneous events: if i_halt and a CMD_NEXT i_rx_done occur in the same cycle, halt wins and no o_step is issued.
- DONE: the pipeline is frozen, with o_pipe_reset=0 so the debug unit can still read state. CMD_LOAD sets o_pipe_reset=1 and goes to LOAD. Others are ignored.
- ERROR: o_pipe_reset=1 and o_error=1. CMD_LOAD clears o_error and restarts the load at address 0. Others are ignored.
- CMD_LOAD entry: entering LOAD from any state sets o_pipe_reset=1, o_valid=0 and o_exec_mode=0.

Decomposition:
- Shared package (debug_pkg): command byte constants, HALT_WORD default, loader state encoding {IDLE, LOAD, READY, RUN, DONE, ERROR}.
- Sub-module word_packer: shift register, 2-bit byte counter, and word-ready strobe. Ports: clk, reset, byte, strobe, clear -> word, word_valid.
- The FSM, address counter and control outputs stay in program_loader.

Test Plan:
- Reset asserted mid-operation -> next cycle: o_pipe_reset=1, all other outputs 0; a following byte 8'h00 produces no write.
- 'L', then 00 00 00 01, then FF FF FF FF -> o_imem_we pulses twice: addr 0 / 32'h0000_0001, then addr 1 / 32'hFFFF_FFFF; o_prog_loaded=1, state READY.
- Loaded image, then 'S', then 'N' twice -> o_exec_mode=1, o_valid=1, o_pipe_reset=0; exactly two one-cycle o_step pulses, each one cycle after i_rx_done.
- Loaded image, then 'C', then 'N', then i_halt=1 -> no o_step; o_valid drops to 0 the cycle after i_halt; a subsequent 'L' sets o_pipe_reset=1.
- NB_ADDR=2, load of 4 non-HALT words -> 4 writes at addr 0..3, then o_error=1; a 5th word gives no write; 'L' clears o_error and the next write lands at addr 0.
- Load with a byte strobe in the same cycle as o_imem_we -> the byte is captured as byte 0 of the next word, and the word content checks correct.
